// File: rtl/depth_seq_pkg.sv
// Shared types and constants for the depth frame sequencer.
package depth_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    DRAW,
    DRAIN,
    SWAP
  } seq_state_t;

  // Farthest depth; wide enough for any practical depth word, truncated at the user
  localparam int DEPTH_MAX_WIDTH = 64;
  localparam logic [DEPTH_MAX_WIDTH-1:0] DEPTH_FAR = '1;

endpackage

// File: rtl/depth_frame_sequencer_addr_hazard_window.sv
// Sliding window of recently issued pixel addresses, used to stall a pixel
// whose address still has a depth write in flight.
module addr_hazard_window
  import depth_seq_pkg::*;
#(
  parameter int DEPTH      = 5,
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  push_valid,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [ADDR_WIDTH-1:0] probe_addr,
  output logic                  hit,
  output logic                  hit_next
);

  logic [DEPTH-1:0]      valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];

  // Age every entry by one slot per cycle; a bubble enters when nothing is pushed
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= push_valid;
      addr_q[0]  <= push_addr;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  // Parallel compare; hit_next skips the oldest slot, which leaves on the next bubble shift
  always_comb begin
    hit      = 1'b0;
    hit_next = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == probe_addr)) begin
        hit = 1'b1;
        if (i < DEPTH - 1) begin
          hit_next = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/depth_frame_sequencer.sv
// Per-frame controller for the depth-tested write pipeline: clears the back
// buffer and depth buffer, streams pixels with address-hazard stalls, drains
// the pipeline and flips the displayed buffer.
module depth_frame_sequencer
  import depth_seq_pkg::*;
#(
  parameter int                      FB_BIT_WIDTH    = 16,
  parameter int                      DEPTH_BIT_WIDTH = 16,
  parameter int                      FB_SIZE         = 76800,
  parameter int                      FB_ADDR_WIDTH   = $clog2(FB_SIZE),
  parameter logic [FB_BIT_WIDTH-1:0] CLEAR_COLOR     = '0,
  parameter int                      PIPE_LATENCY    = 5
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       frame_start_in,
  input  logic                       px_valid_in,
  output logic                       px_ready_out,
  input  logic [FB_ADDR_WIDTH-1:0]   px_addr_in,
  input  logic [FB_BIT_WIDTH-1:0]    px_color_in,
  input  logic [DEPTH_BIT_WIDTH-1:0] px_depth_in,
  input  logic                       raster_done_in,
  output logic                       drawing_out,
  output logic                       fb_we_out,
  output logic                       dp_we_out,
  output logic                       dp_re_out,
  output logic                       fb_front_out,
  output logic [FB_ADDR_WIDTH-1:0]   fb_write_out,
  output logic [FB_ADDR_WIDTH-1:0]   dp_write_out,
  output logic [FB_BIT_WIDTH-1:0]    fb_value_out,
  output logic [DEPTH_BIT_WIDTH-1:0] dp_value_out,
  output logic                       front_sel_out,
  output logic                       busy_out,
  output logic                       frame_done_out
);

  localparam int                         DRAIN_WIDTH = $clog2(PIPE_LATENCY + 1);
  localparam logic [FB_ADDR_WIDTH-1:0]   LAST_ADDR   = FB_ADDR_WIDTH'(FB_SIZE - 1);
  localparam logic [DRAIN_WIDTH-1:0]     DRAIN_LOAD  = DRAIN_WIDTH'(PIPE_LATENCY);
  localparam logic [DEPTH_BIT_WIDTH-1:0] FAR_VALUE   = DEPTH_BIT_WIDTH'(DEPTH_FAR);

  seq_state_t               state;
  logic [FB_ADDR_WIDTH-1:0] clear_cnt;
  logic [DRAIN_WIDTH-1:0]   drain_cnt;
  logic                     done_seen;
  logic                     hit;
  logic                     hit_next;
  logic                     accept;

  addr_hazard_window #(
    .DEPTH      (PIPE_LATENCY),
    .ADDR_WIDTH (FB_ADDR_WIDTH)
  ) u_hazard (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push_valid (accept),
    .push_addr  (px_addr_in),
    .probe_addr (px_addr_in),
    .hit        (hit),
    .hit_next   (hit_next)
  );

  // A pixel is taken only in DRAW, on a handshake, and never onto an in-flight address
  always_comb begin
    accept = (state == DRAW) && px_valid_in && px_ready_out && !hit;
  end

  // Frame FSM; every output is registered from the transition being taken
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state          <= IDLE;
      clear_cnt      <= '0;
      drain_cnt      <= '0;
      done_seen      <= 1'b0;
      px_ready_out   <= 1'b0;
      drawing_out    <= 1'b0;
      fb_we_out      <= 1'b0;
      dp_we_out      <= 1'b0;
      dp_re_out      <= 1'b0;
      fb_front_out   <= 1'b1;
      fb_write_out   <= '0;
      dp_write_out   <= '0;
      fb_value_out   <= '0;
      dp_value_out   <= '0;
      front_sel_out  <= 1'b0;
      busy_out       <= 1'b0;
      frame_done_out <= 1'b0;
    end else begin
      fb_we_out      <= 1'b0;
      dp_we_out      <= 1'b0;
      dp_re_out      <= 1'b0;
      frame_done_out <= 1'b0;
      px_ready_out   <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start_in) begin
            state        <= CLEAR;
            clear_cnt    <= '0;
            done_seen    <= 1'b0;
            busy_out     <= 1'b1;
            fb_we_out    <= 1'b1;
            dp_we_out    <= 1'b1;
            fb_write_out <= '0;
            dp_write_out <= '0;
            fb_value_out <= CLEAR_COLOR;
            dp_value_out <= FAR_VALUE;
          end
        end

        CLEAR: begin
          done_seen <= done_seen | raster_done_in;
          if (clear_cnt == LAST_ADDR) begin
            if (done_seen || raster_done_in) begin
              state     <= DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end else begin
              state        <= DRAW;
              drawing_out  <= 1'b1;
              px_ready_out <= 1'b1;
            end
          end else begin
            clear_cnt    <= clear_cnt + 1'b1;
            fb_we_out    <= 1'b1;
            dp_we_out    <= 1'b1;
            fb_write_out <= clear_cnt + 1'b1;
            dp_write_out <= clear_cnt + 1'b1;
            fb_value_out <= CLEAR_COLOR;
            dp_value_out <= FAR_VALUE;
          end
        end

        DRAW: begin
          if (accept) begin
            fb_we_out    <= 1'b1;
            dp_we_out    <= 1'b1;
            dp_re_out    <= 1'b1;
            fb_write_out <= px_addr_in;
            dp_write_out <= px_addr_in;
            fb_value_out <= px_color_in;
            dp_value_out <= px_depth_in;
            px_ready_out <= 1'b1;
          end else if (raster_done_in) begin
            state       <= DRAIN;
            drawing_out <= 1'b0;
            drain_cnt   <= DRAIN_LOAD;
          end else begin
            px_ready_out <= px_valid_in ? !hit_next : 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt <= DRAIN_WIDTH'(1)) begin
            drain_cnt      <= '0;
            state          <= SWAP;
            front_sel_out  <= ~front_sel_out;
            fb_front_out   <= front_sel_out;
            frame_done_out <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end

        SWAP: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end

        default: begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
